// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver: synchronizes and filters ps2_clk, then deframes start/8 data/odd parity/stop.
// Result pulses appear one cycle after the filtered falling edge; there is no backpressure and the PS/2 device sets the pace.
module ps2_byte_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_key_en,
    output logic [7:0] ps2_key_data,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          ps2_clk_s1, ps2_clk_s2;
    logic          ps2_data_s1, ps2_data_s2;
    logic          filt_clk, filt_clk_d;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          fall;

    assign fall = filt_clk_d & ~filt_clk;
    assign busy = (state != IDLE);

    // The filtered clock only moves after FILTER_LEN consecutive cycles at the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_s1  <= 1'b1;
            ps2_clk_s2  <= 1'b1;
            ps2_data_s1 <= 1'b1;
            ps2_data_s2 <= 1'b1;
            filt_clk    <= 1'b1;
            filt_clk_d  <= 1'b1;
            filt_cnt    <= '0;
        end else begin
            ps2_clk_s1  <= ps2_clk;
            ps2_clk_s2  <= ps2_clk_s1;
            ps2_data_s1 <= ps2_data;
            ps2_data_s2 <= ps2_data_s1;
            filt_clk_d  <= filt_clk;
            if (ps2_clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= ps2_clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            to_cnt       <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            ps2_key_en   <= 1'b0;
            ps2_key_data <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            ps2_key_en <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall) begin
                    if (!ps2_data_s2) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (fall) begin
                // An edge coinciding with the timeout threshold wins and restarts the count.
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        shift_reg <= {ps2_data_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= ps2_data_s2;
                        state      <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!ps2_data_s2) begin
                            frame_err <= 1'b1;
                        end else if (^{shift_reg, parity_bit}) begin
                            ps2_key_en   <= 1'b1;
                            ps2_key_data <= shift_reg;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                endcase
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                to_cnt    <= '0;
                shift_reg <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/ps2_byte_receiver.md
PS2_BYTE_RECEIVER -- requirements
Module: ps2_byte_receiver

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive clk cycles the synchronized ps2_clk must hold a new level before the filtered clock follows it.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 5000: clk cycles without a filtered falling edge before an in-progress frame is abandoned.
REQ-003 The block SHALL have port clk  input  1  system clock; the only clock in the block, and all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 The block SHALL have port ps2_key_en  output  1  one-cycle pulse marking a valid received byte.
REQ-008 The block SHALL have port ps2_key_data  output  8  last valid received byte.
REQ-009 The block SHALL have port parity_err  output  1  one-cycle pulse on an odd-parity failure.
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse on a bad start bit, a bad stop bit or a timeout.
REQ-011 The block SHALL have port busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-012 Input conditioning SHALL use a 2-flop synchronizer on each of ps2_clk and ps2_data, with both synchronizer stages reset to 1.
REQ-013 Filtered clock SHALL:
- reset to 1;
- take level v only after the synchronized ps2_clk has equalled v for FILTER_LEN consecutive cycles;
- ignore shorter glitches.
REQ-014 A falling edge SHALL be detected in cycle E, when the filtered clock was 1 in the previous cycle and is 0 in cycle E. Synchronized ps2_data SHALL be sampled in cycle E.
REQ-015 The state machine SHALL have exactly four states: IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, a falling edge with data=0 SHALL move the block to DATA with the bit counter cleared. A falling edge with data=1 SHALL pulse frame_err in cycle E+1 and leave the block in IDLE.
REQ-017 In DATA, each falling edge SHALL shift the sampled bit into the shift register LSB-first. The 8th edge SHALL move the block to PARITY.
REQ-018 In PARITY, the falling edge SHALL capture the parity bit and move the block to STOP.
REQ-019 Parity SHALL be odd: the frame is good when the XOR of the 8 data bits and the parity bit equals 1.
REQ-020 In STOP, the falling edge SHALL return the block to IDLE and produce, in cycle E+1, exactly one of the following:
- stop bit = 1 and parity good: ps2_key_en = 1, and ps2_key_data is loaded with the shifted byte;
- stop bit = 1 and parity bad: parity_err = 1 only;
- stop bit = 0: frame_err = 1 only (takes precedence over a parity failure).
REQ-021 ps2_key_data SHALL change only on a valid byte and SHALL hold its value between valid bytes.
REQ-022 ps2_key_en, parity_err and frame_err SHALL each be high for exactly one cycle per event and SHALL never be high in the same cycle.
REQ-023 Timeout counter SHALL:
- clear on every falling edge and in IDLE;
- increment every cycle outside IDLE;
- on reaching TIMEOUT_CYCLES, return the block to IDLE, pulse frame_err in the next cycle, and discard the partial byte without touching ps2_key_data.
REQ-024 A falling edge arriving in the same cycle the timeout threshold is reached SHALL take priority: the edge is processed and the counter clears.
REQ-025 busy SHALL be high whenever the state is not IDLE, combinationally from state.

Reset
REQ-026 On reset: state = IDLE, bit counter = 0, timeout counter = 0, shift register = 0, filtered clock = 1.
REQ-027 On reset all outputs SHALL be 0: ps2_key_en, ps2_key_data = 8'h00, parity_err, frame_err, busy.
REQ-028 Reset asserted mid-frame SHALL discard the frame and SHALL produce no pulse in the cycle after reset deasserts.

Verification (FILTER_LEN=4, TIMEOUT_CYCLES=200, PS/2 bit period 40 clk cycles)
REQ-029 Valid frame, start 0, data 0x1C LSB-first, parity 0, stop 1 -> single ps2_key_en pulse one cycle after the stop-bit filtered edge; ps2_key_data = 0x1C; no error pulses.
REQ-030 Back-to-back valid frames 0xE0 (parity 0), 0xF0 (parity 1), 0x74 (parity 1) -> three ps2_key_en pulses with data 0xE0, 0xF0, 0x74 in order; busy low between frames.
REQ-031 Frame 0x1C with parity 1 -> one parity_err pulse, no ps2_key_en, and ps2_key_data retains its prior value.
REQ-032 Frame 0x1C with stop bit 0 -> frame_err only.
REQ-033 Idle-state falling edge with data 1 -> frame_err pulse, state stays IDLE.
REQ-034 Stall after 4 data bits for more than 200 cycles -> frame_err after the threshold, then busy = 0; a following valid frame 0x29 is received correctly.
REQ-035 2-cycle low glitches on ps2_clk during IDLE -> no state change and no pulses.
REQ-036 Reset asserted after the 5th data bit -> busy = 0 and no pulses; the next valid frame is received correctly.
